cla_gp_input_stage: RTL and testbench

- Registered operand front-end for the 8-bit carry-lookahead adder.
- Accepts operand pairs with a valid/ready handshake and applies add/subtract conditioning.
- Produces registered per-bit generate/propagate vectors and carry-in (c0), which feed the CLA carry-logic blocks directly.
- Contains a 2-entry skid buffer so that in_ready is a registered output and full throughput is sustained under backpressure.

---
 rtl/cla_gp_input_stage_if.sv | 29 ++
 rtl/cla_gp_input_stage.sv | 115 +++++++++++
 tb/tb_cla_gp_input_stage.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/cla_gp_input_stage_if.sv
// Handshake/bus bundle for the CLA generate/propagate input stage.
//   Upstream side : in_valid, in_ready, a, b, sub
//   Downstream side: out_valid, out_ready, g, p, c0
// modport slave  : the stage itself
// modport master : the environment driving operands and consuming g/p/c0
interface cla_gp_input_stage_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic             c0;

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, g, p, c0
  );

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, g, p, c0
  );
endinterface

// File: rtl/cla_gp_input_stage.sv
// Registered operand front-end for the carry-lookahead adder.
// Conditions each accepted operand pair for add/subtract (b inverted and
// c0 = sub when subtracting), and registers per-bit generate/propagate
// vectors plus carry-in. A 2-entry skid buffer (main M + skid S) keeps
// in_ready a registered output while sustaining one transfer per cycle.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - cla_gp_input_stage_if slave: in_valid/in_ready/a/b/sub in,
//           out_valid/out_ready/g/p/c0 out
module cla_gp_input_stage #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cla_gp_input_stage_if.slave    bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] m_g_q, m_p_q;
  logic             m_c_q;
  logic [WIDTH-1:0] s_g_q, s_p_q;
  logic             s_c_q;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] in_g, in_p;

  logic in_xfer, out_xfer;
  logic load_m_in, load_m_skid, load_s;

  // Input-side conditioning
  always_comb begin
    b_eff = bus.sub ? ~bus.b : bus.b;
    in_g  = bus.a & b_eff;
    in_p  = bus.a ^ b_eff;
  end

  assign bus.in_ready  = (state_q != FULL);
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.g         = m_g_q;
  assign bus.p         = m_p_q;
  assign bus.c0        = m_c_q;

  assign in_xfer  = bus.in_valid  && bus.in_ready;
  assign out_xfer = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d     = state_q;
    load_m_in   = 1'b0;
    load_m_skid = 1'b0;
    load_s      = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d   = ONE;
          load_m_in = 1'b1;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          load_m_in = 1'b1;
        end else if (in_xfer) begin
          state_d = FULL;
          load_s  = 1'b1;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the drain case exists
        if (out_xfer) begin
          state_d     = ONE;
          load_m_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      m_g_q   <= '0;
      m_p_q   <= '0;
      m_c_q   <= 1'b0;
      s_g_q   <= '0;
      s_p_q   <= '0;
      s_c_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_m_in) begin
        m_g_q <= in_g;
        m_p_q <= in_p;
        m_c_q <= bus.sub;
      end else if (load_m_skid) begin
        m_g_q <= s_g_q;
        m_p_q <= s_p_q;
        m_c_q <= s_c_q;
      end
      if (load_s) begin
        s_g_q <= in_g;
        s_p_q <= in_p;
        s_c_q <= bus.sub;
      end
    end
  end

endmodule

// File: tb/tb_cla_gp_input_stage.sv
// Directed self-checking bench for cla_gp_input_stage.
module tb_cla_gp_input_stage;

  localparam int unsigned WIDTH = 8;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  cla_gp_input_stage_if #(.WIDTH(WIDTH)) bus ();

  cla_gp_input_stage #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] av, input logic [7:0] bv, input logic s);
    bus.in_valid = v;
    bus.a        = av;
    bus.b        = bv;
    bus.sub      = s;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [7:0] eg,
                           input logic [7:0] ep, input logic ec);
    check({tag, ".valid"}, {31'd0, bus.out_valid}, {31'd0, v});
    check({tag, ".g"},     {24'd0, bus.g},         {24'd0, eg});
    check({tag, ".p"},     {24'd0, bus.p},         {24'd0, ep});
    check({tag, ".c0"},    {31'd0, bus.c0},        {31'd0, ec});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    bus.out_ready = 1'b0;

    #12;
    check_out("reset", 1'b0, 8'h00, 8'h00, 1'b0);
    check("reset.in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Add: 3C + 0F
    bus.out_ready = 1'b1;
    drive(1'b1, 8'h3C, 8'h0F, 1'b0);
    step();
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    check_out("add", 1'b1, 8'h0C, 8'h33, 1'b0);
    step();
    check("add.drain", {31'd0, bus.out_valid}, 32'd0);

    // Subtract: 3C - 0F, b_eff = F0
    drive(1'b1, 8'h3C, 8'h0F, 1'b1);
    step();
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    check_out("sub", 1'b1, 8'h30, 8'hCC, 1'b1);

    // Subtract with b=0: b_eff all-ones, g=a, p=~a
    drive(1'b1, 8'h5A, 8'h00, 1'b1);
    step();
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    check_out("sub_b0", 1'b1, 8'h5A, 8'hA5, 1'b1);
    step();
    check("sub_b0.drain", {31'd0, bus.out_valid}, 32'd0);

    // Backpressure
    bus.out_ready = 1'b0;
    drive(1'b1, 8'h01, 8'h01, 1'b0);
    step();
    check("bp.rdy1", {31'd0, bus.in_ready}, 32'd1);
    drive(1'b1, 8'h02, 8'h02, 1'b0);
    step();
    check("bp.rdy2", {31'd0, bus.in_ready}, 32'd0);
    check_out("bp.hold1", 1'b1, 8'h01, 8'h00, 1'b0);
    drive(1'b1, 8'h03, 8'h03, 1'b0);
    step();
    check("bp.rdy3", {31'd0, bus.in_ready}, 32'd0);
    check_out("bp.hold2", 1'b1, 8'h01, 8'h00, 1'b0);
    bus.out_ready = 1'b1;
    step();
    check_out("bp.second", 1'b1, 8'h02, 8'h00, 1'b0);
    check("bp.rdy4", {31'd0, bus.in_ready}, 32'd1);
    step();
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    check_out("bp.third", 1'b1, 8'h03, 8'h00, 1'b0);
    step();
    check("bp.drain", {31'd0, bus.out_valid}, 32'd0);

    // Streaming: 16 back-to-back items
    for (int i = 0; i < 16; i++) begin
      logic [7:0] av, bv;
      av = 8'(i);
      bv = 8'(i + 1);
      drive(1'b1, av, bv, 1'b0);
      step();
      check_out($sformatf("stream%0d", i), 1'b1, av & bv, av ^ bv, 1'b0);
      check($sformatf("stream%0d.rdy", i), {31'd0, bus.in_ready}, 32'd1);
    end
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    step();
    check("stream.drain", {31'd0, bus.out_valid}, 32'd0);

    // Reset mid-operation from FULL
    bus.out_ready = 1'b0;
    drive(1'b1, 8'h11, 8'h22, 1'b0);
    step();
    drive(1'b1, 8'h33, 8'h44, 1'b1);
    step();
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    check("mid.full", {31'd0, bus.in_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("mid.rst", 1'b0, 8'h00, 8'h00, 1'b0);
    check("mid.rst.rdy", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 8'hFF, 8'hFF, 1'b0);
    step();
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    check_out("post_rst", 1'b1, 8'hFF, 8'h00, 1'b0);
    step();
    check("post_rst.drain", {31'd0, bus.out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
